// File: rtl/fan_ctrl_pkg.sv
// Shared types and helpers for the fan controller.
//   fan_state_t  : controller FSM state (IDLE/COOL/HEAT)
//   effort_t     : requested effort level (OFF/LOW/MED/HIGH)
//   temp_t       : 7-bit unsigned temperature
//   encode_speed : maps (effort, direction) to the plant's fan_speed code
package fan_ctrl_pkg;

    typedef logic [6:0] temp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COOL = 2'd1,
        HEAT = 2'd2
    } fan_state_t;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        LOW  = 2'd1,
        MED  = 2'd2,
        HIGH = 2'd3
    } effort_t;

    // The plant's speed codes run backwards when heating.
    function automatic logic [1:0] encode_speed(effort_t effort, logic heat);
        logic [1:0] code;
        case (effort)
            LOW:     code = heat ? 2'd3 : 2'd1;
            MED:     code = 2'd2;
            HIGH:    code = heat ? 2'd1 : 2'd3;
            default: code = 2'd0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/fan_controller_if.sv
// Bus between the plant/host side and the fan controller.
//   master : drives enable, sample_en, temperature, setpoint
//   slave  : drives fan_speed, sign, state_o, filt_temp, filt_valid
interface fan_controller_if;
    import fan_ctrl_pkg::*;

    logic       enable;
    logic       sample_en;
    temp_t      temperature;
    temp_t      setpoint;
    logic [1:0] fan_speed;
    logic       sign;
    logic [1:0] state_o;
    temp_t      filt_temp;
    logic       filt_valid;

    modport master (
        output enable, sample_en, temperature, setpoint,
        input  fan_speed, sign, state_o, filt_temp, filt_valid
    );

    modport slave (
        input  enable, sample_en, temperature, setpoint,
        output fan_speed, sign, state_o, filt_temp, filt_valid
    );
endinterface

// File: rtl/temp_avg_filter.sv
// Temperature smoothing stage.
// Configuration macro FAN_CTRL_FILTER_EN:
//   defined   : 4-sample moving average, valid after 4 samples
//   undefined : registered raw sample, valid after the first sample
// Ports:
//   CLK, RST     : clock, async active-high reset
//   sample_en_i  : accept sample_i this cycle
//   sample_i     : raw temperature
//   filt_o       : filtered temperature (registered)
//   valid_o      : filter primed
module temp_avg_filter
    import fan_ctrl_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  sample_en_i,
    input  temp_t sample_i,
    output temp_t filt_o,
    output logic  valid_o
);

`ifdef FAN_CTRL_FILTER_EN
    temp_t      tap_q [4];
    temp_t      tap_d [4];
    logic [8:0] sum_q, sum_d;
    logic [2:0] cnt_q, cnt_d;

    // Running sum: add the newest sample, drop the one falling off the end.
    always_comb begin
        tap_d = tap_q;
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (sample_en_i) begin
            tap_d[0] = sample_i;
            tap_d[1] = tap_q[0];
            tap_d[2] = tap_q[1];
            tap_d[3] = tap_q[2];
            sum_d    = sum_q + 9'(sample_i) - 9'(tap_q[3]);
            if (cnt_q != 3'd4)
                cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tap_q <= '{default: '0};
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            tap_q <= tap_d;
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    assign filt_o  = sum_q[8:2];
    assign valid_o = (cnt_q == 3'd4);
`else
    temp_t raw_q;
    logic  valid_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            raw_q   <= '0;
            valid_q <= 1'b0;
        end else if (sample_en_i) begin
            raw_q   <= sample_i;
            valid_q <= 1'b1;
        end
    end

    assign filt_o  = raw_q;
    assign valid_o = valid_q;
`endif

endmodule

// File: rtl/fan_controller.sv
// Closed-loop thermostat: filtered temperature in, fan command out.
// Optional averaging filter selected by FAN_CTRL_FILTER_EN (see temp_avg_filter).
// Ports:
//   CLK, RST : clock, async active-high reset
//   bus      : fan_controller_if.slave (enable, sample_en, temperature,
//              setpoint in; fan_speed, sign, state_o, filt_temp, filt_valid out)
//
// state | meaning
// IDLE  | inside dead band or disabled, fan off, sign held
// COOL  | temperature above setpoint, sign=0
// HEAT  | temperature below setpoint, sign=1
module fan_controller
    import fan_ctrl_pkg::*;
#(
    parameter int HYST      = 2,
    parameter int BAND_LOW  = 5,
    parameter int BAND_HIGH = 15,
    parameter int MIN_DWELL = 8
) (
    input  logic           CLK,
    input  logic           RST,
    fan_controller_if.slave bus
);

    localparam logic signed [7:0] HYST_S  = 8'(HYST);
    localparam logic [7:0]        BLOW_U  = 8'(BAND_LOW);
    localparam logic [7:0]        BHIGH_U = 8'(BAND_HIGH);
    localparam logic [7:0]        DWELL_U = 8'(MIN_DWELL);

    temp_t filt_temp;
    logic  filt_valid;

    temp_avg_filter u_filter (
        .CLK         (CLK),
        .RST         (RST),
        .sample_en_i (bus.sample_en),
        .sample_i    (bus.temperature),
        .filt_o      (filt_temp),
        .valid_o     (filt_valid)
    );

    // Pipeline stage aligning the control decision with the filter output.
    logic       adv_q, en_q;
    temp_t      sp_q;

    fan_state_t state_q, state_d;
    logic [7:0] dwell_q, dwell_d;
    effort_t    effort_q, effort_d;
    logic       sign_q, sign_d;

    logic signed [7:0] err;
    logic [7:0]        mag;
    logic [7:0]        dwell_inc;
    effort_t           effort_mag;

    assign err        = $signed({1'b0, filt_temp}) - $signed({1'b0, sp_q});
    assign mag        = err[7] ? 8'(-err) : 8'(err);
    assign dwell_inc  = (dwell_q >= DWELL_U) ? DWELL_U : dwell_q + 8'd1;
    assign effort_mag = (mag < BLOW_U) ? LOW : (mag < BHIGH_U) ? MED : HIGH;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            adv_q    <= 1'b0;
            en_q     <= 1'b0;
            sp_q     <= '0;
            state_q  <= IDLE;
            dwell_q  <= '0;
            effort_q <= OFF;
            sign_q   <= 1'b0;
        end else begin
            adv_q    <= bus.sample_en;
            en_q     <= bus.enable;
            if (bus.sample_en)
                sp_q <= bus.setpoint;
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            effort_q <= effort_d;
            sign_q   <= sign_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        effort_d = effort_q;
        sign_d   = sign_q;
        if (!en_q) begin
            // Disable wins over dwell and does not need a sample.
            state_d  = IDLE;
            dwell_d  = '0;
            effort_d = OFF;
        end else if (adv_q && filt_valid) begin
            case (state_q)
                IDLE: begin
                    if (err > HYST_S) begin
                        state_d = COOL;
                        sign_d  = 1'b0;
                    end else if (err < -HYST_S) begin
                        state_d = HEAT;
                        sign_d  = 1'b1;
                    end
                end
                // The current sample counts toward dwell before the exit check.
                COOL: if (err <= 8'sd0 && dwell_inc >= DWELL_U) state_d = IDLE;
                HEAT: if (err >= 8'sd0 && dwell_inc >= DWELL_U) state_d = IDLE;
                default: state_d = IDLE;
            endcase
            dwell_d  = (state_d != state_q) ? 8'd0 : dwell_inc;
            effort_d = (state_d == IDLE) ? OFF : effort_mag;
        end
    end

    always_comb begin
        bus.fan_speed  = (state_q == IDLE) ? 2'd0 : encode_speed(effort_q, sign_q);
        bus.sign       = sign_q;
        bus.state_o    = state_q;
        bus.filt_temp  = filt_temp;
        bus.filt_valid = filt_valid;
    end

endmodule
